// File: rtl/mux41_rr_sched.sv
// mux41_rr_sched: round-robin grant of a 4:1 bit mux with bounded hold and registered mux output
module mux41_rr_sched #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] data,
  output logic [3:0] grant,
  output logic [1:0] key,
  output logic       busy,
  output logic       out,
  output logic       out_valid
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t st, st_n;
  logic [1:0] ptr, ptr_n, key_n, nk;
  logic [3:0] cnt, cnt_n, grant_n, oth;
  logic take;
  // first set bit of m, scanning upward from s with wrap
  function automatic logic [1:0] pick(input logic [3:0] m, input logic [1:0] s);
    logic [1:0] r, j;
    logic f;
    r = s;
    f = 1'b0;
    for (int i = 0; i < 4; i++) begin
      j = s + 2'(i);
      if (!f && m[j]) begin
        r = j;
        f = 1'b1;
      end
    end
    return r;
  endfunction
  assign oth = req & ~(4'b0001 << key);
  always_comb begin
    st_n = st;
    ptr_n = ptr;
    key_n = key;
    grant_n = grant;
    cnt_n = cnt;
    take = 1'b0;
    nk = key;
    if (st == IDLE) begin
      take = |req;
      nk = pick(req, ptr);
    end else if (!req[key] || (cnt == 4'(HOLD_MAX) && |oth)) begin
      take = |oth;
      nk = pick(oth, key + 2'd1);
      st_n = |oth ? GRANT : IDLE;
      grant_n = 4'b0000;
    end else
      cnt_n = cnt == 4'(HOLD_MAX) ? cnt : cnt + 4'd1;
    if (take) begin
      st_n = GRANT;
      key_n = nk;
      grant_n = 4'b0001 << nk;
      cnt_n = 4'd1;
      ptr_n = nk + 2'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      ptr <= 2'd0;
      cnt <= 4'd0;
      grant <= 4'b0000;
      key <= 2'd0;
      out <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      st <= st_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      grant <= grant_n;
      key <= key_n;
      out <= |grant_n ? data[key_n] : out;
      out_valid <= |grant_n;
    end
  end
  assign busy = |grant;
endmodule

// File: tb/tb_mux41_rr_sched.sv
// tb_mux41_rr_sched: directed vectors with a queued scoreboard checked by an independent monitor
module tb_mux41_rr_sched;
  typedef struct packed {
    logic [3:0] g;
    logic [1:0] k;
    logic       o;
    logic       v;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req = 4'b0000, data = 4'b0000, grant;
  logic [1:0] key;
  logic busy, out, out_valid;
  exp_t q[$];
  exp_t e;
  int vecs = 0, errs = 0;
  mux41_rr_sched #(.HOLD_MAX(2)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .grant(grant),
    .key(key), .busy(busy), .out(out), .out_valid(out_valid)
  );
  always #5 clk = ~clk;
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] d,
                      input logic [3:0] g, input logic [1:0] k, input logic o, input logic v);
    @(negedge clk);
    rst = r;
    req = rq;
    data = d;
    q.push_back({g, k, o, v});
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      vecs++;
      if ({grant, key, out, out_valid, busy} !== {e.g, e.k, e.o, e.v, e.v}) begin
        errs++;
        $display("FAIL vec%0d: got grant=%b key=%0d out=%b out_valid=%b busy=%b, want grant=%b key=%0d out=%b out_valid=%b busy=%b",
                 vecs, grant, key, out, out_valid, busy, e.g, e.k, e.o, e.v, e.v);
      end
    end
  end
  initial begin
    // reset with everything requesting, then first grant from ptr=0
    step(1, 4'b1111, 4'b1111, 4'b0000, 0, 0, 0);
    step(1, 4'b1111, 4'b1111, 4'b0000, 0, 0, 0);
    step(0, 4'b1111, 4'b1111, 4'b0001, 0, 1, 1);
    step(0, 4'b0000, 4'b1111, 4'b0000, 0, 1, 0);
    // sole requester 2 holds indefinitely, then drops
    for (int i = 0; i < 10; i++) step(0, 4'b0100, 4'b0100, 4'b0100, 2, 1, 1);
    step(0, 4'b0000, 4'b0100, 4'b0000, 2, 1, 0);
    // full rotation with HOLD_MAX=2 from ptr=0
    step(1, 4'b0000, 4'b0101, 4'b0000, 0, 0, 0);
    step(0, 4'b1111, 4'b0101, 4'b0001, 0, 1, 1);
    step(0, 4'b1111, 4'b0101, 4'b0001, 0, 1, 1);
    step(0, 4'b1111, 4'b0101, 4'b0010, 1, 0, 1);
    step(0, 4'b1111, 4'b0101, 4'b0010, 1, 0, 1);
    step(0, 4'b1111, 4'b0101, 4'b0100, 2, 1, 1);
    step(0, 4'b1111, 4'b0101, 4'b0100, 2, 1, 1);
    step(0, 4'b1111, 4'b0101, 4'b1000, 3, 0, 1);
    step(0, 4'b1111, 4'b0101, 4'b1000, 3, 0, 1);
    step(0, 4'b1111, 4'b0101, 4'b0001, 0, 1, 1);
    step(0, 4'b0000, 4'b0101, 4'b0000, 0, 1, 0);
    // early release: 0 -> 1 handover with no idle cycle
    step(1, 4'b0000, 4'b0001, 4'b0000, 0, 0, 0);
    step(0, 4'b0011, 4'b0001, 4'b0001, 0, 1, 1);
    step(0, 4'b0010, 4'b0001, 4'b0010, 1, 0, 1);
    step(0, 4'b0000, 4'b0001, 4'b0000, 1, 0, 0);
    // pointer fairness: 3 -> 0 wraps, 0 -> 3 after preempt, 3 release -> 0
    step(0, 4'b1001, 4'b1000, 4'b1000, 3, 1, 1);
    step(0, 4'b1001, 4'b1000, 4'b1000, 3, 1, 1);
    step(0, 4'b1001, 4'b1000, 4'b0001, 0, 0, 1);
    step(0, 4'b1001, 4'b1000, 4'b0001, 0, 0, 1);
    step(0, 4'b1001, 4'b1000, 4'b1000, 3, 1, 1);
    step(0, 4'b0001, 4'b1000, 4'b0001, 0, 0, 1);
    step(0, 4'b0000, 4'b1000, 4'b0000, 0, 0, 0);
    // reset mid-grant, then arbitration restarts from ptr=0
    step(0, 4'b0100, 4'b0100, 4'b0100, 2, 1, 1);
    step(0, 4'b0100, 4'b0100, 4'b0100, 2, 1, 1);
    step(1, 4'b0100, 4'b0100, 4'b0000, 0, 0, 0);
    step(0, 4'b1100, 4'b1100, 4'b0100, 2, 1, 1);
    step(0, 4'b1100, 4'b1100, 4'b0100, 2, 1, 1);
    step(0, 4'b1100, 4'b1100, 4'b1000, 3, 1, 1);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      errs++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
